// File: rtl/alu_operand_loader.sv
// ---------------------------------------------------------------------------
// alu_operand_loader
//   Operator-side front end for a 4-bit combinational ALU. One debounced
//   push-button steps through LOAD_A -> LOAD_B -> LOAD_OP. Each step latches
//   the switches into a registered ALU input. After the op is loaded, one EXEC
//   cycle captures the ALU flags. The carry/borrow of an add/sub can be
//   chained into Cin for the next operation.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   btn_n      step button, active-low, asynchronous and bouncy
//   sw         4-bit operand switches
//   sel_sw     3-bit operation switches (111 = no-op)
//   flag_o/c/z/e  ALU overflow, carry/borrow, zero and error flags
//   A, B, Sel, Cin  registered ALU inputs
//   flags_led  captured {O,C,Z,E} of the last executed operation
//   stage_led  one-hot step: [0] LOAD_A, [1] LOAD_B, [2] LOAD_OP, 000 otherwise
//   done       1-cycle pulse when the flags are captured
// ---------------------------------------------------------------------------
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit CHAIN_CIN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic [3:0] sw,
  input  logic [2:0] sel_sw,
  input  logic       flag_o,
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic       flag_e,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] Sel,
  output logic       Cin,
  output logic [3:0] flags_led,
  output logic [2:0] stage_led,
  output logic       done
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  // -------------------------------------------------------------------------
  // Button path: 2-FF synchroniser followed by a stability-count debouncer.
  // -------------------------------------------------------------------------
  logic          sync1_q, sync2_q;
  logic          deb_q;
  logic [CW-1:0] cnt_q;
  logic          step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      step_q  <= 1'b0;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // The DEBOUNCE_CYCLES-th consecutive differing cycle: accept the
        // level. A step is only produced on the press (1 -> 0) direction.
        deb_q  <= sync2_q;
        cnt_q  <= '0;
        step_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer with registered ALU inputs and captured flags.
  // -------------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] a_q, b_q;
  logic [2:0] sel_q;
  logic       cin_q;
  logic [3:0] flags_q;
  logic       done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD_A;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      sel_q   <= 3'b111;
      cin_q   <= 1'b0;
      flags_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_LOAD_A: if (step_q) begin
          a_q     <= sw;
          state_q <= S_LOAD_B;
        end
        S_LOAD_B: if (step_q) begin
          b_q     <= sw;
          state_q <= S_LOAD_OP;
        end
        S_LOAD_OP: if (step_q) begin
          sel_q   <= sel_sw;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // Inputs have been stable for this whole cycle, so the
          // combinational ALU result is settled by the closing edge.
          flags_q <= {flag_o, flag_c, flag_z, flag_e};
          done_q  <= 1'b1;
          if (CHAIN_CIN && (sel_q == 3'b000 || sel_q == 3'b001))
            cin_q <= flag_c;
          state_q <= S_SHOW;
        end
        S_SHOW: if (step_q) begin
          state_q <= S_LOAD_A;
        end
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  always_comb begin
    stage_led = 3'b000;
    case (state_q)
      S_LOAD_A:  stage_led = 3'b001;
      S_LOAD_B:  stage_led = 3'b010;
      S_LOAD_OP: stage_led = 3'b100;
      default:   stage_led = 3'b000;
    endcase
  end

  assign A         = a_q;
  assign B         = b_q;
  assign Sel       = sel_q;
  assign Cin       = cin_q;
  assign flags_led = flags_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n, btn_n;
  logic [3:0] sw;
  logic [2:0] sel_sw;
  logic       flag_o, flag_c, flag_z, flag_e;
  logic [3:0] A, B, flags_led;
  logic [2:0] Sel, stage_led;
  logic       Cin, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_operand_loader #(.DEBOUNCE_CYCLES(DB), .CHAIN_CIN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .sw(sw), .sel_sw(sel_sw),
    .flag_o(flag_o), .flag_c(flag_c), .flag_z(flag_z), .flag_e(flag_e),
    .A(A), .B(B), .Sel(Sel), .Cin(Cin), .flags_led(flags_led),
    .stage_led(stage_led), .done(done)
  );

  // Behavioural 4-bit ALU: returns {O,C,Z,E}.
  function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s, input logic ci);
    int r, ai, bi;
    logic [3:0] res;
    logic o, c, e;
    ai = int'(a); bi = int'(b);
    o = 1'b0; c = 1'b0; e = 1'b0; r = 0;
    case (s)
      3'd0: begin r = ai + bi + int'(ci); c = (r > 15); end
      3'd1: begin r = ai - bi - int'(ci); c = (r < 0); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = ai * bi;
      3'd5: if (bi == 0) e = 1'b1; else r = ai / bi;
      3'd6: r = int'(a ^ b);
      default: r = 0;
    endcase
    res = r[3:0];
    if (s == 3'd0) o = (a[3] == b[3]) && (res[3] != a[3]);
    if (s == 3'd1) o = (a[3] != b[3]) && (res[3] != a[3]);
    return {o, c, (res == 4'd0), e};
  endfunction

  always_comb {flag_o, flag_c, flag_z, flag_e} = alu_ref(A, B, Sel, Cin);

  // Cycle counter and done/EXEC timing monitor.
  int cyc = 0;
  int done_cnt = 0, done_cyc = -1, exec_cyc = -100;
  logic [2:0] prev_stage = 3'b000;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    prev_stage <= stage_led;
    if (prev_stage == 3'b100 && stage_led == 3'b000) exec_cyc <= cyc;
    if (done) begin
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
  end

  logic exp_cin = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int hold);
    btn_n = 1'b0;
    repeat (hold) @(negedge clk);
    btn_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic back_to_a();
    press(12);
    check("stage_after_show", 32'(stage_led), 32'h1);
  endtask

  // Starts in LOAD_A, ends in SHOW.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    int d0;
    logic [3:0] f;
    sw = a;
    press(12);
    check("stage_b", 32'(stage_led), 32'h2);
    check("A", 32'(A), 32'(a));
    sw = b;
    press(12);
    sw = ~b;
    sel_sw = ~s;
    repeat (6) @(negedge clk);
    check("A_hold", 32'(A), 32'(a));
    check("B", 32'(B), 32'(b));
    check("stage_op", 32'(stage_led), 32'h4);
    sel_sw = s;
    d0 = done_cnt;
    press(12);
    f = alu_ref(a, b, s, exp_cin);
    if (s == 3'd0 || s == 3'd1) exp_cin = f[2];
    check("Sel", 32'(Sel), 32'(s));
    check("flags_led", 32'(flags_led), 32'(f));
    check("Cin", 32'(Cin), 32'(exp_cin));
    check("stage_show", 32'(stage_led), 32'h0);
    check("done_count", 32'(done_cnt), 32'(d0 + 1));
    check("done_timing", 32'(done_cyc), 32'(exec_cyc + 1));
    $display("[TB] op A=%0d B=%0d Sel=%0d -> flags=%b Cin=%0b", a, b, s, flags_led, Cin);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; btn_n = 1'b1; sw = 4'd0; sel_sw = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_A", 32'(A), 32'h0);
    check("rst_B", 32'(B), 32'h0);
    check("rst_Sel", 32'(Sel), 32'h7);
    check("rst_Cin", 32'(Cin), 32'h0);
    check("rst_flags", 32'(flags_led), 32'h0);
    check("rst_stage", 32'(stage_led), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_stage", 32'(stage_led), 32'h1);

    // Directed chaining sequence.
    run_op(4'd9, 4'd8, 3'd0);
    check("add_carry_cin", 32'(Cin), 32'h1);
    back_to_a(); run_op(4'd2, 4'd5, 3'd1);
    back_to_a(); run_op(4'd7, 4'd2, 3'd1);
    check("sub_no_borrow_cin", 32'(Cin), 32'h0);
    back_to_a(); run_op(4'd9, 4'd8, 3'd0);
    back_to_a(); run_op(4'd3, 4'd3, 3'd7);
    check("noop_zero", 32'(flags_led[1]), 32'h1);
    back_to_a(); run_op(4'd6, 4'd2, 3'd4);
    check("mul_cin_kept", 32'(Cin), 32'h1);

    // Glitch and bounce rejection while in SHOW.
    btn_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_n = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_no_step", 32'(stage_led), 32'h0);
    for (int i = 0; i < 10; i++) begin
      btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    btn_n = 1'b1;
    repeat (12) @(negedge clk);
    check("bounce_no_step", 32'(stage_led), 32'h0);

    // Long hold: one step, accepted DEBOUNCE_CYCLES+3 edges after the press.
    btn_n = 1'b0;
    k = 0;
    while (stage_led == 3'b000 && k < 50) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check("press_latency", 32'(k), 32'(DB + 3));
    repeat (200 - k) @(negedge clk);
    check("hold_one_step", 32'(stage_led), 32'h1);
    btn_n = 1'b1;
    repeat (12) @(negedge clk);
    check("release_no_step", 32'(stage_led), 32'h1);

    // Randomized operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      back_to_a();
    end

    // Reset in the middle of a sequence.
    sw = 4'd5; press(12);
    sw = 4'd3; press(12);
    check("pre_rst_stage", 32'(stage_led), 32'h4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_A", 32'(A), 32'h0);
    check("mid_rst_B", 32'(B), 32'h0);
    check("mid_rst_Sel", 32'(Sel), 32'h7);
    check("mid_rst_Cin", 32'(Cin), 32'h0);
    check("mid_rst_flags", 32'(flags_led), 32'h0);
    check("mid_rst_stage", 32'(stage_led), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after_mid_rst_stage", 32'(stage_led), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
